// File: rtl/count_code_pkg.sv
// Shared digit-code constants and 4-bit code <-> decimal conversion helpers
// for the cascaded decade counter.
package count_code_pkg;

    localparam int CODE_8421 = 0;
    localparam int CODE_2421 = 1;
    localparam int CODE_XS3  = 2;

    // Decimal digits above 9 are treated as 0 so a bad load value can never
    // produce an out-of-code state.
    function automatic logic [3:0] encode_digit(input int code, input logic [3:0] digit);
        logic [3:0] d;
        logic [3:0] result;
        d = (digit > 4'd9) ? 4'd0 : digit;
        case (code)
            CODE_2421: result = (d < 4'd5) ? d : d + 4'd6;
            CODE_XS3:  result = d + 4'd3;
            default:   result = d;
        endcase
        return result;
    endfunction

    function automatic logic [3:0] decode_digit(input int code, input logic [3:0] enc);
        logic [3:0] value;
        value = 4'd0;
        case (code)
            CODE_2421: begin
                if (enc <= 4'd4) begin
                    value = enc;
                end else if (enc >= 4'd11) begin
                    value = enc - 4'd6;
                end
            end
            CODE_XS3: begin
                if (enc >= 4'd3 && enc <= 4'd12) begin
                    value = enc - 4'd3;
                end
            end
            default: begin
                if (enc <= 4'd9) begin
                    value = enc;
                end
            end
        endcase
        return value;
    endfunction

endpackage

// File: rtl/count_code_digit.sv
// One decade digit of the counter: holds a CODE-encoded digit, steps it up or
// down on request and reports when it sits at the wrap value for the direction.
module count_code_digit
    import count_code_pkg::*;
#(
    parameter int CODE = CODE_2421
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       clr,
    input  logic       load,
    input  logic [3:0] load_digit,
    input  logic       step,
    input  logic       up,
    output logic [3:0] code,
    output logic       at_term
);

    localparam logic [3:0] ZERO_CODE = encode_digit(CODE, 4'd0);

    logic [3:0] value;
    logic [3:0] stepped;

    assign value   = decode_digit(CODE, code);
    assign at_term = up ? (value == 4'd9) : (value == 4'd0);

    always_comb begin
        stepped = value;
        if (up) begin
            stepped = at_term ? 4'd0 : value + 4'd1;
        end else begin
            stepped = at_term ? 4'd9 : value - 4'd1;
        end
    end

    // All state moves on the falling clock edge.
    always_ff @(negedge clock or negedge reset) begin
        if (!reset) begin
            code <= ZERO_CODE;
        end else if (clr) begin
            code <= ZERO_CODE;
        end else if (load) begin
            code <= encode_digit(CODE, load_digit);
        end else if (step) begin
            code <= encode_digit(CODE, stepped);
        end
    end

endmodule

// File: rtl/count_decade_n.sv
// Cascaded DIGITS-digit up/down decade counter with selectable digit code.
// Define COUNT_CODE_CHECK_EN to flag loads that contain non-decimal nibbles on err.
module count_decade_n
    import count_code_pkg::*;
#(
    parameter int DIGITS = 2,
    parameter int CODE   = CODE_2421
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  clr,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    input  logic                  en,
    input  logic                  up,
    output logic [4*DIGITS-1:0]   count,
    output logic                  carry,
    output logic                  err
);

    logic [DIGITS-1:0] term;
    logic [DIGITS:0]   chain;
    logic              wrap;

    // chain[i] is high when every digit below i is at its wrap value,
    // which is exactly when digit i must step.
    always_comb begin
        chain    = '0;
        chain[0] = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            chain[i+1] = chain[i] & term[i];
        end
    end

    assign wrap = chain[DIGITS];

    for (genvar g = 0; g < DIGITS; g++) begin : gen_digit
        count_code_digit #(
            .CODE(CODE)
        ) u_digit (
            .clock      (clock),
            .reset      (reset),
            .clr        (clr),
            .load       (load),
            .load_digit (load_val[4*g +: 4]),
            .step       (en & chain[g]),
            .up         (up),
            .code       (count[4*g +: 4]),
            .at_term    (term[g])
        );
    end

    always_ff @(negedge clock or negedge reset) begin
        if (!reset) begin
            carry <= 1'b0;
        end else begin
            carry <= !clr && !load && en && wrap;
        end
    end

`ifdef COUNT_CODE_CHECK_EN
    logic bad_load;

    always_comb begin
        bad_load = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (load_val[4*i +: 4] > 4'd9) begin
                bad_load = 1'b1;
            end
        end
    end

    // Sticky until clr or reset; a clean load does not clear it.
    always_ff @(negedge clock or negedge reset) begin
        if (!reset) begin
            err <= 1'b0;
        end else if (clr) begin
            err <= 1'b0;
        end else if (load && bad_load) begin
            err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_count_decade_n.sv
// Bench for count_decade_n (DIGITS=2, Aiken code): a decimal-value model
// checked every cycle, pinned by literal expectations and driven with random traffic.
module tb_count_decade_n;

    logic       clock;
    logic       reset;
    logic       clr;
    logic       load;
    logic [7:0] load_val;
    logic       en;
    logic       up;
    logic [7:0] count;
    logic       carry;
    logic       err;

    int   total;
    int   bad;
    int   mVal;
    logic mCarry;
    logic mErr;
    int   lsd;
    int   msd;

`ifdef COUNT_CODE_CHECK_EN
    localparam logic ERR_ON = 1'b1;
`else
    localparam logic ERR_ON = 1'b0;
`endif

    count_decade_n #(
        .DIGITS(2),
        .CODE  (1)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .clr      (clr),
        .load     (load),
        .load_val (load_val),
        .en       (en),
        .up       (up),
        .count    (count),
        .carry    (carry),
        .err      (err)
    );

    initial begin
        clock = 1'b1;
        forever #5 clock = ~clock;
    end

    function automatic logic [3:0] aiken(input int d);
        case (d)
            0: return 4'b0000;
            1: return 4'b0001;
            2: return 4'b0010;
            3: return 4'b0011;
            4: return 4'b0100;
            5: return 4'b1011;
            6: return 4'b1100;
            7: return 4'b1101;
            8: return 4'b1110;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [7:0] expectCount(input int v);
        return {aiken(v / 10), aiken(v % 10)};
    endfunction

    // Decimal-value model of the counter, stepped on the same falling edge.
    always @(negedge clock or negedge reset) begin
        if (!reset) begin
            mVal = 0; mCarry = 1'b0; mErr = 1'b0;
        end else if (clr) begin
            mVal = 0; mCarry = 1'b0; mErr = 1'b0;
        end else if (load) begin
            lsd = int'(load_val[3:0]);
            msd = int'(load_val[7:4]);
            if (ERR_ON && (lsd > 9 || msd > 9)) mErr = 1'b1;
            if (lsd > 9) lsd = 0;
            if (msd > 9) msd = 0;
            mVal = msd * 10 + lsd;
            mCarry = 1'b0;
        end else if (en) begin
            if (up) begin
                mCarry = (mVal == 99);
                mVal = (mVal + 1) % 100;
            end else begin
                mCarry = (mVal == 0);
                mVal = (mVal + 99) % 100;
            end
        end else begin
            mCarry = 1'b0;
        end
    end

    task automatic compare(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic checkOutput();
        compare("model_count", count, expectCount(mVal));
        compare("model_carry", {7'd0, carry}, {7'd0, mCarry});
        compare("model_err", {7'd0, err}, {7'd0, mErr});
    endtask

    task automatic applyStimulus(input logic c, input logic l, input logic [7:0] lv,
                                 input logic e, input logic u);
        clr = c; load = l; load_val = lv; en = e; up = u;
        @(negedge clock);
        @(posedge clock);
        #1;
        checkOutput();
    endtask

    initial begin
        logic dir;
        int   r;
        logic [7:0] lv;
        total = 0; bad = 0;
        clr = 1'b0; load = 1'b0; load_val = 8'h00; en = 1'b0; up = 1'b1;
        reset = 1'b1;
        #2 reset = 1'b0;
        #1;
        compare("rst_count", count, 8'h00);
        compare("rst_carry", {7'd0, carry}, 8'h00);
        compare("rst_err", {7'd0, err}, 8'h00);
        @(posedge clock);
        #1 reset = 1'b1;

        repeat (5) applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        compare("up5", count, 8'h0B);
        repeat (5) applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        compare("up10", count, 8'h10);

        applyStimulus(1'b0, 1'b1, 8'h99, 1'b0, 1'b1);
        compare("load99", count, 8'hFF);
        compare("load99_carry", {7'd0, carry}, 8'h00);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        compare("wrap_up", count, 8'h00);
        compare("wrap_up_carry", {7'd0, carry}, 8'h01);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        compare("carry_drop", {7'd0, carry}, 8'h00);

        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        compare("wrap_down", count, 8'hFF);
        compare("wrap_down_carry", {7'd0, carry}, 8'h01);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        compare("down_98", count, 8'hFE);
        compare("down_98_carry", {7'd0, carry}, 8'h00);

        applyStimulus(1'b0, 1'b1, 8'h42, 1'b1, 1'b1);
        compare("load_wins", count, 8'h42);
        compare("load_wins_carry", {7'd0, carry}, 8'h00);
        applyStimulus(1'b1, 1'b1, 8'h42, 1'b0, 1'b1);
        compare("clr_wins", count, 8'h00);

        applyStimulus(1'b0, 1'b1, 8'hA3, 1'b0, 1'b1);
        compare("load_a3", count, 8'h03);
        compare("load_a3_err", {7'd0, err}, {7'd0, ERR_ON});
        repeat (3) applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        compare("count_06", count, 8'h0C);
        compare("err_sticky", {7'd0, err}, {7'd0, ERR_ON});
        applyStimulus(1'b0, 1'b1, 8'h15, 1'b0, 1'b1);
        compare("load_15", count, 8'h1B);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        compare("count_16", count, 8'h1C);

        // Reset lands mid-period, well before the next falling edge.
        clr = 1'b0; load = 1'b0; en = 1'b1; up = 1'b1;
        #2 reset = 1'b0;
        #1;
        compare("midrst_count", count, 8'h00);
        compare("midrst_carry", {7'd0, carry}, 8'h00);
        compare("midrst_err", {7'd0, err}, 8'h00);
        @(negedge clock);
        #1;
        compare("rst_hold", count, 8'h00);
        @(posedge clock);
        #1 reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        compare("after_rst", count, 8'h01);

        applyStimulus(1'b0, 1'b1, 8'hA3, 1'b0, 1'b1);
        compare("err_again", {7'd0, err}, {7'd0, ERR_ON});
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, 1'b1);
        compare("clr_err", {7'd0, err}, 8'h00);
        compare("clr_count", count, 8'h00);

        dir = 1'b1;
        for (int i = 0; i < 600; i++) begin
            r = int'($urandom_range(0, 99));
            if ($urandom_range(0, 15) == 0) dir = ~dir;
            case ($urandom_range(0, 5))
                0: lv = 8'($urandom_range(0, 255));
                1: lv = 8'h99;
                2: lv = 8'h00;
                default: lv = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            endcase
            applyStimulus(r < 3, (r >= 3 && r < 12), lv, $urandom_range(0, 4) != 0, dir);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
